// File: rtl/hpu_pkg.sv
// Shared types and helpers for the HPU bundling datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hpu_pkg;

    // Sign packer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int WORD_DEFAULT = 32;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sign_packer.sv
// Snapshots the per-lane sign bits on flush and streams them as WORD-bit words.
// Latency: flush accepted at edge t -> first m_valid in cycle t+SETTLE+1, then one word per cycle.
// Backpressure: m_ready low holds m_data/m_last/m_valid; a flush while busy is dropped and latched sticky.
module sign_packer
    import hpu_pkg::*;
#(
    parameter int LANES  = 512,   // must be a multiple of WORD
    parameter int WORD   = WORD_DEFAULT,
    parameter int SETTLE = 3      // must be >= 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [LANES-1:0] sign_vec,
    output logic [WORD-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             flush_drop
);

    localparam int NWORDS = LANES / WORD;
    localparam int IW     = idx_width(NWORDS);
    // The settle counter only ever holds 0..SETTLE-1.
    localparam int CW     = idx_width(SETTLE);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NWORDS - 1);
    localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE - 1);

    state_t                       state;
    state_t                       state_nxt;
    logic   [CW-1:0]              cnt;
    logic   [IW-1:0]              idx;
    // Snapshot viewed as an array of words so word selection is a plain mux on idx.
    logic   [NWORDS-1:0][WORD-1:0] snap;

    logic accept;    // flush taken this cycle, (re)start the settle wait
    logic snap_en;   // settle done, capture sign_vec this cycle
    logic drop;      // flush arrived while a snapshot is in flight
    logic hs;        // word handshake

    assign hs     = m_valid & m_ready;
    assign m_last = (state == SEND) && (idx == LAST_IDX);
    assign m_data = (state == SEND) ? snap[idx] : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; a flush on the final handshake chains straight into WAIT.
    always_comb begin
        state_nxt = state;
        m_valid   = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        snap_en   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                drop = flush;
                if (cnt == '0) begin
                    snap_en   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                if (m_ready && m_last) begin
                    if (flush) begin
                        accept    = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drop = flush;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle counter, snapshot capture, word index and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            flush_drop <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= SETTLE_LD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            if (snap_en) begin
                snap <= sign_vec;
                idx  <= '0;
            end else if (hs) begin
                idx <= m_last ? '0 : idx + IW'(1);
            end

            if (drop) begin
                flush_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sign_packer.sv
// Directed bench for sign_packer with LANES=64, WORD=32, SETTLE=3.
// Each table row is one clock cycle: inputs driven after the falling edge, outputs compared in the same cycle.
// A final hand-written sequence streams a snapshot under pseudo-random m_ready with a bounded wait.
module tb_sign_packer;

    localparam int LANES  = 64;
    localparam int WORD   = 32;
    localparam int SETTLE = 3;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [LANES-1:0] sign_vec;
    logic [WORD-1:0]  m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic             flush_drop;

    sign_packer #(
        .LANES  (LANES),
        .WORD   (WORD),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .sign_vec   (sign_vec),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .flush_drop (flush_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        rdy;
        logic [63:0] vec;
        logic        chk;
        logic        v;
        logic        last;
        logic        busy;
        logic        drop;
        logic [31:0] data;
    } row_t;

    row_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [63:0] V   = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] VX  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] V1S = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] V2  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] V3  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] V4  = 64'h5555_AAAA_0F0F_F0F0;

    task automatic add(input logic r, input logic f, input logic rd, input logic [63:0] vv,
                       input logic c, input logic ev, input logic el, input logic eb,
                       input logic ed, input logic [31:0] edat);
        row_t t;
        t.rst = r; t.flush = f; t.rdy = rd; t.vec = vv; t.chk = c;
        t.v = ev; t.last = el; t.busy = eb; t.drop = ed; t.data = edat;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int          got_words;
        logic        holding;
        logic [31:0] held;
        logic [31:0] exp_w [2];

        rst      = 1'b1;
        flush    = 1'b0;
        m_ready  = 1'b1;
        sign_vec = '0;

        //   rst flush rdy vec   chk v  last busy drop data
        // Reset.
        add(1, 0, 1, V,   0, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 0, 0, 32'h0);
        // Basic: flush, 3 settle cycles, two words, back to idle.
        add(0, 1, 1, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V,   1, 1, 1, 1, 0, 32'hA5A5_0000);
        add(0, 0, 1, V,   1, 0, 0, 0, 0, 32'h0);
        // Backpressure: m_ready low for the first four valid cycles.
        add(0, 1, 0, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 0, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 0, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 0, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 0, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 0, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 0, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 0, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V,   1, 1, 1, 1, 0, 32'hA5A5_0000);
        add(0, 0, 1, V,   1, 0, 0, 0, 0, 32'h0);
        // Isolation: only the value on the last settle cycle is captured.
        add(0, 1, 1, VX,  1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, VX,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, VX,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V1S, 1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V1S, 1, 1, 1, 1, 0, 32'hA5A5_0000);
        add(0, 0, 1, V1S, 1, 0, 0, 0, 0, 32'h0);
        // Dropped flush during WAIT: sticky flag, still exactly two words.
        add(0, 1, 1, V2,  1, 0, 0, 0, 0, 32'h0);
        add(0, 1, 1, V2,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V2,  1, 0, 0, 1, 1, 32'h0);
        add(0, 0, 1, V2,  1, 0, 0, 1, 1, 32'h0);
        add(0, 0, 1, V2,  1, 1, 0, 1, 1, 32'h89AB_CDEF);
        add(0, 0, 1, V2,  1, 1, 1, 1, 1, 32'h0123_4567);
        add(0, 0, 1, V2,  1, 0, 0, 0, 1, 32'h0);
        add(0, 0, 1, V2,  1, 0, 0, 0, 1, 32'h0);
        add(1, 0, 1, V2,  1, 0, 0, 0, 1, 32'h0);
        add(0, 0, 1, V2,  1, 0, 0, 0, 0, 32'h0);
        // Back-to-back: flush on the final handshake restarts the settle wait.
        add(0, 1, 1, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 1, 1, V3,  1, 1, 1, 1, 0, 32'hA5A5_0000);
        add(0, 0, 1, V3,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V3,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V3,  1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V3,  1, 1, 0, 1, 0, 32'hCAFE_F00D);
        add(0, 0, 1, V3,  1, 1, 1, 1, 0, 32'hDEAD_BEEF);
        add(0, 0, 1, V3,  1, 0, 0, 0, 0, 32'h0);
        // Reset mid-SEND, then a clean snapshot.
        add(0, 1, 1, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(1, 0, 1, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 1, 1, V,   1, 0, 0, 0, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 0, 0, 1, 0, 32'h0);
        add(0, 0, 1, V,   1, 1, 0, 1, 0, 32'hFFFF_1234);
        add(0, 0, 1, V,   1, 1, 1, 1, 0, 32'hA5A5_0000);
        add(0, 0, 1, V,   1, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst      = tbl[i].rst;
            flush    = tbl[i].flush;
            m_ready  = tbl[i].rdy;
            sign_vec = tbl[i].vec;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("row%0d m_valid", i),    64'(m_valid),    64'(tbl[i].v));
                check($sformatf("row%0d m_last", i),     64'(m_last),     64'(tbl[i].last));
                check($sformatf("row%0d busy", i),       64'(busy),       64'(tbl[i].busy));
                check($sformatf("row%0d flush_drop", i), 64'(flush_drop), 64'(tbl[i].drop));
                check($sformatf("row%0d m_data", i),     64'(m_data),     64'(tbl[i].data));
            end
        end

        // Random backpressure: words arrive in order, held stable while stalled.
        exp_w[0]  = V4[31:0];
        exp_w[1]  = V4[63:32];
        got_words = 0;
        holding   = 1'b0;
        held      = '0;
        @(negedge clk);
        rst      = 1'b0;
        sign_vec = V4;
        flush    = 1'b1;
        m_ready  = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 60 && got_words < 2; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (holding) begin
                check($sformatf("rnd c%0d held m_valid", c), 64'(m_valid), 64'd1);
                check($sformatf("rnd c%0d held m_data", c),  64'(m_data),  64'(held));
            end
            if (m_valid) begin
                if (m_ready) begin
                    check($sformatf("rnd word%0d data", got_words), 64'(m_data), 64'(exp_w[got_words]));
                    check($sformatf("rnd word%0d last", got_words), 64'(m_last), 64'(got_words == 1));
                    got_words++;
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    held    = m_data;
                end
            end
            @(negedge clk);
        end
        check("rnd words received", 64'(got_words), 64'd2);
        m_ready = 1'b1;
        #1;
        check("rnd busy after last", 64'(busy), 64'd0);
        check("rnd flush_drop clear", 64'(flush_drop), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
